rpn_stack_evaluator: RTL

Parametrised successor to the fixed-width RPN calculator. It consumes a postfix token stream from the infix-to-postfix converter over a stb/ack handshake. Signed operands are held on a DEPTH-entry stack and evaluated as ADD/SUB/MUL/DIV/MOD; DIV and MOD use an iterative multi-cycle divider. On an END token it emits a result plus an error code; the calculator before it had no error reporting.

---
 rtl/rpn_stack_evaluator.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rpn_stack_evaluator.sv
// rpn_stack_evaluator
//   Evaluates a postfix (RPN) token stream over a stb/ack handshake. Signed
//   numbers are pushed on a DEPTH-entry stack of ACC_W-bit words; operators
//   pop b (top) and a (next) and push a op b. DIV/MOD run on a restoring
//   divider producing one quotient bit per cycle. An END token or any error
//   produces one result/error-code pair, after which the stack is cleared.
//
// Ports
//   CLK, RST           clock (rising edge), async active-high reset
//   input_stb          token valid
//   input_data         number, or opcode in bits [2:0] when is_input_operator
//   is_input_operator  1 = input_data carries an opcode
//   input_ack          token accepted on CLK edge where input_stb & input_ack
//   output_stb         result valid
//   output_data        signed result (0 on error)
//   output_err         0 OK, 1 OVERFLOW, 2 UNDERFLOW, 3 DIVZERO, 4 LEFTOVER, 5 BADOP
//   output_ack         result consumed on CLK edge where output_stb & output_ack

module rpn_stack_evaluator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              input_stb,
  input  logic [DATA_W-1:0] input_data,
  input  logic              is_input_operator,
  output logic              input_ack,
  output logic              output_stb,
  output logic [ACC_W-1:0]  output_data,
  output logic [2:0]        output_err,
  input  logic              output_ack
);

  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int DIV_CNT_W = $clog2(ACC_W + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_END = 3'd7;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
  localparam logic [2:0] ERR_DIVZERO   = 3'd3;
  localparam logic [2:0] ERR_LEFTOVER  = 3'd4;
  localparam logic [2:0] ERR_BADOP     = 3'd5;

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_EXEC,
    ST_DIV,
    ST_OUT
  } state_t;

  state_t state, next_state;

  logic [ACC_W-1:0]     stack [DEPTH];
  logic [CNT_W-1:0]     count;
  logic [2:0]           op_q;

  logic [DIV_CNT_W-1:0] div_cnt;
  logic [ACC_W-1:0]     div_rem;
  logic [ACC_W-1:0]     div_quo;
  logic [ACC_W-1:0]     div_dsr;
  logic                 div_neg_q;
  logic                 div_neg_r;

  logic [2:0]           opcode;
  logic [IDX_W-1:0]     top_idx;
  logic [IDX_W-1:0]     next_idx;
  logic [ACC_W-1:0]     top_val;
  logic [ACC_W-1:0]     next_val;
  logic [ACC_W-1:0]     push_val;
  logic [ACC_W-1:0]     alu_result;
  logic [ACC_W-1:0]     a_mag;
  logic [ACC_W-1:0]     b_mag;
  logic [ACC_W:0]       div_shift;
  logic [ACC_W:0]       div_trial;
  logic                 div_ge;
  logic                 div_done;
  logic [ACC_W-1:0]     div_q_signed;
  logic [ACC_W-1:0]     div_r_signed;
  logic [ACC_W-1:0]     div_result;

  logic                 do_push;
  logic                 do_exec;
  logic                 do_div_wb;
  logic                 start_div;
  logic                 latch_op;
  logic                 load_out;
  logic [ACC_W-1:0]     load_data;
  logic [2:0]           load_err;
  logic                 out_done;

  assign input_ack = (state == ST_ACCEPT);
  assign opcode    = input_data[2:0];

  // top/next indices wrap harmlessly when count < 2; those reads are never used
  assign top_idx   = IDX_W'(count - CNT_W'(1));
  assign next_idx  = IDX_W'(count - CNT_W'(2));
  assign top_val   = stack[top_idx];
  assign next_val  = stack[next_idx];
  assign push_val  = ACC_W'($signed(input_data));

  // Single-cycle operators; MUL keeps the low ACC_W bits, which are the same
  // for signed and unsigned operands.
  always_comb begin
    alu_result = next_val + top_val;
    case (op_q)
      OP_SUB:  alu_result = next_val - top_val;
      OP_MUL:  alu_result = next_val * top_val;
      default: alu_result = next_val + top_val;
    endcase
  end

  // Divider works on magnitudes; the most negative value maps to itself, which
  // read as unsigned is exactly its magnitude.
  assign a_mag     = next_val[ACC_W-1] ? -next_val : next_val;
  assign b_mag     = top_val[ACC_W-1]  ? -top_val  : top_val;
  assign div_shift = {div_rem, div_quo[ACC_W-1]};
  assign div_trial = div_shift - {1'b0, div_dsr};
  assign div_ge    = ~div_trial[ACC_W];
  assign div_done  = (div_cnt == DIV_CNT_W'(ACC_W));

  // Sign fix-up: quotient negative when signs differ, remainder follows the
  // dividend. MIN / -1 yields magnitude 2^(ACC_W-1) unnegated, i.e. MIN.
  assign div_q_signed = div_neg_q ? -div_quo : div_quo;
  assign div_r_signed = div_neg_r ? -div_rem : div_rem;
  assign div_result   = (op_q == OP_MOD) ? div_r_signed : div_q_signed;

  assign do_exec   = (state == ST_EXEC);
  assign do_div_wb = (state == ST_DIV) && div_done;
  assign out_done  = (state == ST_OUT) && output_ack;

  always_comb begin
    next_state = state;
    do_push    = 1'b0;
    start_div  = 1'b0;
    latch_op   = 1'b0;
    load_out   = 1'b0;
    load_data  = '0;
    load_err   = ERR_OK;
    unique case (state)
      ST_ACCEPT: begin
        if (input_stb) begin
          if (!is_input_operator) begin
            if (count == CNT_W'(DEPTH)) begin
              next_state = ST_OUT;
              load_out   = 1'b1;
              load_err   = ERR_OVERFLOW;
            end else begin
              do_push = 1'b1;
            end
          end else begin
            case (opcode)
              OP_END: begin
                next_state = ST_OUT;
                load_out   = 1'b1;
                if (count == CNT_W'(1)) begin
                  load_data = top_val;
                end else if (count == '0) begin
                  load_err = ERR_UNDERFLOW;
                end else begin
                  load_err = ERR_LEFTOVER;
                end
              end
              OP_ADD, OP_SUB, OP_MUL: begin
                if (count < CNT_W'(2)) begin
                  next_state = ST_OUT;
                  load_out   = 1'b1;
                  load_err   = ERR_UNDERFLOW;
                end else begin
                  next_state = ST_EXEC;
                  latch_op   = 1'b1;
                end
              end
              OP_DIV, OP_MOD: begin
                if (count < CNT_W'(2)) begin
                  next_state = ST_OUT;
                  load_out   = 1'b1;
                  load_err   = ERR_UNDERFLOW;
                end else if (top_val == '0) begin
                  next_state = ST_OUT;
                  load_out   = 1'b1;
                  load_err   = ERR_DIVZERO;
                end else begin
                  next_state = ST_DIV;
                  latch_op   = 1'b1;
                  start_div  = 1'b1;
                end
              end
              default: begin
                next_state = ST_OUT;
                load_out   = 1'b1;
                load_err   = ERR_BADOP;
              end
            endcase
          end
        end
      end
      ST_EXEC: next_state = ST_ACCEPT;
      ST_DIV: begin
        if (div_done) begin
          next_state = ST_ACCEPT;
        end
      end
      ST_OUT: begin
        if (output_ack) begin
          next_state = ST_ACCEPT;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_ACCEPT;
    end else begin
      state <= next_state;
    end
  end

  // Control registers, result holding registers and divider iteration state.
  // Reset returns state to ACCEPT, which also abandons any divide in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count       <= '0;
      op_q        <= OP_ADD;
      output_stb  <= 1'b0;
      output_data <= '0;
      output_err  <= ERR_OK;
      div_cnt     <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_dsr     <= '0;
      div_neg_q   <= 1'b0;
      div_neg_r   <= 1'b0;
    end else begin
      if (do_push) begin
        count <= count + CNT_W'(1);
      end else if (do_exec || do_div_wb) begin
        count <= count - CNT_W'(1);
      end else if (out_done) begin
        count <= '0;
      end

      if (load_out) begin
        output_stb  <= 1'b1;
        output_data <= load_data;
        output_err  <= load_err;
      end else if (out_done) begin
        output_stb <= 1'b0;
      end

      if (latch_op) begin
        op_q <= opcode;
      end

      if (start_div) begin
        div_cnt   <= '0;
        div_rem   <= '0;
        div_quo   <= a_mag;
        div_dsr   <= b_mag;
        div_neg_q <= next_val[ACC_W-1] ^ top_val[ACC_W-1];
        div_neg_r <= next_val[ACC_W-1];
      end else if ((state == ST_DIV) && !div_done) begin
        div_cnt <= div_cnt + DIV_CNT_W'(1);
        div_rem <= div_ge ? div_trial[ACC_W-1:0] : div_shift[ACC_W-1:0];
        div_quo <= {div_quo[ACC_W-2:0], div_ge};
      end
    end
  end

  // Stack storage; entries above count are don't-care, so no reset is needed.
  // Operator results overwrite operand a's slot, b's slot is freed by count-1.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      stack[IDX_W'(count)] <= push_val;
    end else if (do_exec) begin
      stack[next_idx] <= alu_result;
    end else if (do_div_wb) begin
      stack[next_idx] <= div_result;
    end
  end

endmodule
